// File: rtl/cpu_core_mc.sv
// Multi-cycle Harvard CPU core: FETCH/DECODE/EXEC/WB control FSM with a req/ack
// instruction port, an internal register file and a combinational debug read port.
module cpu_core_mc #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned PC_W    = 6,
   parameter int unsigned NREGS   = 8,
   parameter int unsigned PC_STEP = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [PC_W-1:0]            imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_data,
   output logic [DATA_W-1:0]          out,
   output logic [PC_W-1:0]            pc_out,
   output logic                       zero,
   output logic                       halted,
   input  logic [$clog2(NREGS)-1:0]   dbg_raddr,
   output logic [DATA_W-1:0]          dbg_rdata
);

   localparam int unsigned RW = $clog2(NREGS);

   localparam logic [3:0] OpAdd  = 4'd0;
   localparam logic [3:0] OpSub  = 4'd1;
   localparam logic [3:0] OpAnd  = 4'd2;
   localparam logic [3:0] OpOr   = 4'd3;
   localparam logic [3:0] OpXor  = 4'd4;
   localparam logic [3:0] OpAddi = 4'd5;
   localparam logic [3:0] OpBeqz = 4'd6;
   localparam logic [3:0] OpHalt = 4'd7;

   typedef enum logic [2:0] {
      StFetch,
      StDecode,
      StExec,
      StWb,
      StHalt
   } state_e;

   state_e              state_q, state_d;
   logic [PC_W-1:0]     pc_q;
   logic [31:0]         ir_q;
   logic [DATA_W-1:0]   a_q, b_q;
   logic                take_q;
   logic [DATA_W-1:0]   out_q;
   logic                zero_q;
   logic [DATA_W-1:0]   regs_q [NREGS];

   logic [3:0]          opcode;
   logic [RW-1:0]       rd, rs1, rs2;
   logic [DATA_W-1:0]   imm_ext;
   logic [PC_W-1:0]     target;
   logic [PC_W-1:0]     pc_next;
   logic [DATA_W-1:0]   rs1_val, rs2_val;
   logic [DATA_W-1:0]   alu_res;
   logic                is_alu;
   logic                unused_ir;

   // Instruction fields, always decoded from the latched IR.
   assign opcode  = ir_q[31:28];
   assign rd      = ir_q[24 +: RW];
   assign rs1     = ir_q[20 +: RW];
   assign rs2     = ir_q[16 +: RW];
   assign imm_ext = DATA_W'($signed(ir_q[15:0]));
   assign target  = ir_q[PC_W-1:0];
   assign is_alu  = (opcode <= OpAddi);

   assign unused_ir = ^ir_q;

   // r0 is hardwired to zero on every read path.
   assign rs1_val   = (rs1 == '0) ? '0 : regs_q[rs1];
   assign rs2_val   = (rs2 == '0) ? '0 : regs_q[rs2];
   assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs_q[dbg_raddr];

   assign pc_next = (opcode == OpBeqz && take_q) ? target : pc_q + PC_W'(PC_STEP);

   always_comb begin
      alu_res = '0;
      case (opcode)
         OpAdd, OpAddi: alu_res = a_q + b_q;
         OpSub:         alu_res = a_q - b_q;
         OpAnd:         alu_res = a_q & b_q;
         OpOr:          alu_res = a_q | b_q;
         OpXor:         alu_res = a_q ^ b_q;
         default:       alu_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StFetch:  if (imem_ack) state_d = StDecode;
         StDecode: state_d = (opcode == OpHalt) ? StHalt : StExec;
         StExec:   state_d = StWb;
         StWb:     state_d = StFetch;
         StHalt:   state_d = StHalt;
         default:  state_d = StFetch;
      endcase
   end

   assign imem_req  = (state_q == StFetch) && !reset;
   assign imem_addr = pc_q;
   assign pc_out    = pc_q;
   assign out       = out_q;
   assign zero      = zero_q;
   assign halted    = (state_q == StHalt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StFetch;
         pc_q    <= '0;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         take_q  <= 1'b0;
         out_q   <= '0;
         zero_q  <= 1'b0;
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         case (state_q)
            StFetch: begin
               if (imem_ack) ir_q <= imem_data;
            end
            StDecode: begin
               a_q <= rs1_val;
               b_q <= (opcode == OpAddi) ? imm_ext : rs2_val;
            end
            StExec: begin
               if (is_alu) begin
                  out_q  <= alu_res;
                  zero_q <= (alu_res == '0);
               end
               take_q <= (a_q == '0);
            end
            StWb: begin
               // out_q already holds this instruction's result from EXEC.
               if (is_alu && rd != '0) regs_q[rd] <= out_q;
               pc_q <= pc_next;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Self-checking bench for cpu_core_mc: instruction-level reference model checked
// every cycle, plus directed programs with hand-computed expectations.
module tb_cpu_core_mc;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [5:0]  imem_addr;
   logic        imem_ack = 1'b1;
   logic [31:0] imem_data;
   logic [15:0] out;
   logic [5:0]  pc_out;
   logic        zero;
   logic        halted;
   logic [2:0]  dbg_raddr = 3'd0;
   logic [15:0] dbg_rdata;

   logic [31:0] mem [64];
   assign imem_data = mem[imem_addr];

   int n_cmp = 0;
   int n_fail = 0;

   cpu_core_mc #(
      .DATA_W (16),
      .PC_W   (6),
      .NREGS  (8),
      .PC_STEP(2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .imem_req (imem_req),
      .imem_addr(imem_addr),
      .imem_ack (imem_ack),
      .imem_data(imem_data),
      .out      (out),
      .pc_out   (pc_out),
      .zero     (zero),
      .halted   (halted),
      .dbg_raddr(dbg_raddr),
      .dbg_rdata(dbg_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ins(input int op, input int rd, input int rs1, input int rs2,
                                       input logic [15:0] imm);
      ins = {op[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm};
   endfunction

   // ---------------- instruction-level reference model ----------------
   logic        m_valid = 1'b0;
   logic [5:0]  m_pc = '0;
   logic [15:0] m_out = '0;
   logic        m_zero = 1'b0;
   logic        m_halted = 1'b0;
   logic        m_hpend = 1'b0;
   int          m_busy = 0;
   logic [15:0] m_reg [8];
   logic [31:0] w;
   logic [3:0]  op;
   logic [2:0]  f_rd, f_s1, f_s2;
   logic [15:0] imm, r;

   // Each accepted fetch is applied architecturally at once; the core needs
   // three more cycles to expose it (one for HALT to enter the halted state).
   always @(posedge clk) begin
      if (reset) begin
         m_valid = 1'b1;
         m_pc = '0; m_out = '0; m_zero = 1'b0; m_halted = 1'b0; m_hpend = 1'b0; m_busy = 0;
         for (int i = 0; i < 8; i++) m_reg[i] = '0;
      end else if (m_valid && !m_halted) begin
         if (m_busy != 0) begin
            m_busy--;
            if (m_busy == 0 && m_hpend) begin
               m_halted = 1'b1;
               m_hpend = 1'b0;
            end
         end else if (imem_ack) begin
            w = mem[m_pc];
            op = w[31:28]; f_rd = w[26:24]; f_s1 = w[22:20]; f_s2 = w[18:16]; imm = w[15:0];
            if (op == 4'd7) begin
               m_hpend = 1'b1;
               m_busy = 1;
            end else begin
               m_busy = 3;
               if (op <= 4'd5) begin
                  case (op)
                     4'd0: r = m_reg[f_s1] + m_reg[f_s2];
                     4'd1: r = m_reg[f_s1] - m_reg[f_s2];
                     4'd2: r = m_reg[f_s1] & m_reg[f_s2];
                     4'd3: r = m_reg[f_s1] | m_reg[f_s2];
                     4'd4: r = m_reg[f_s1] ^ m_reg[f_s2];
                     default: r = m_reg[f_s1] + imm;
                  endcase
                  m_out = r;
                  m_zero = (r == 16'd0);
                  if (f_rd != 3'd0) m_reg[f_rd] = r;
                  m_pc = m_pc + 6'd2;
               end else if (op == 4'd6) begin
                  m_pc = (m_reg[f_s1] == 16'd0) ? imm[5:0] : m_pc + 6'd2;
               end else begin
                  m_pc = m_pc + 6'd2;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("imem_req", {31'd0, imem_req}, {31'd0, !reset && !m_halted && m_busy == 0});
         check("halted", {31'd0, halted}, {31'd0, m_halted});
         if (m_busy == 0) begin
            check("pc_out", {26'd0, pc_out}, {26'd0, m_pc});
            check("imem_addr", {26'd0, imem_addr}, {26'd0, m_pc});
            check("out", {16'd0, out}, {16'd0, m_out});
            check("zero", {31'd0, zero}, {31'd0, m_zero});
            check("dbg_rdata", {16'd0, dbg_rdata}, {16'd0, m_reg[dbg_raddr]});
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
         dbg_raddr = dbg_raddr + 3'd1;
      end
   endtask

   task automatic peek(input string name, input int idx, input logic [15:0] exp);
      dbg_raddr = idx[2:0];
      #1;
      check(name, {16'd0, dbg_rdata}, {16'd0, exp});
   endtask

   task automatic begin_test();
      reset = 1'b1;
      cyc(1);
      for (int i = 0; i < 64; i++) mem[i] = 32'h8000_0000;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h8000_0000;

      // Reset held two cycles, then ADDI r1,r0,5.
      begin_test();
      mem[0] = ins(5, 1, 0, 0, 16'd5);
      imem_ack = 1'b1;
      cyc(1);
      check("req_in_reset", {31'd0, imem_req}, 32'd0);
      reset = 1'b0;
      #1;
      check("req_after_release", {31'd0, imem_req}, 32'd1);
      cyc(4);
      peek("t1_r1", 1, 16'd5);
      check("t1_out", {16'd0, out}, 32'd5);
      check("t1_zero", {31'd0, zero}, 32'd0);
      check("t1_pc", {26'd0, pc_out}, 32'd2);

      // SUB of equal values sets zero; ADD afterwards clears it.
      begin_test();
      mem[0] = ins(5, 1, 0, 0, 16'd7);
      mem[2] = ins(5, 2, 0, 0, 16'd7);
      mem[4] = ins(1, 3, 1, 2, 16'd0);
      mem[6] = ins(0, 4, 1, 2, 16'd0);
      cyc(1);
      reset = 1'b0;
      cyc(12);
      peek("t2_r3", 3, 16'd0);
      check("t2_zero", {31'd0, zero}, 32'd1);
      check("t2_pc", {26'd0, pc_out}, 32'd6);
      cyc(4);
      peek("t2_r4", 4, 16'd14);
      check("t2_out", {16'd0, out}, 32'd14);
      check("t2_zero_clr", {31'd0, zero}, 32'd0);

      // Wrap-around arithmetic and writes to r0.
      begin_test();
      mem[0] = ins(5, 1, 0, 0, 16'hFFFF);
      mem[2] = ins(5, 1, 1, 0, 16'd1);
      mem[4] = ins(5, 0, 0, 0, 16'd9);
      cyc(1);
      reset = 1'b0;
      cyc(4);
      peek("t3_r1_ffff", 1, 16'hFFFF);
      cyc(4);
      peek("t3_r1_wrap", 1, 16'd0);
      check("t3_zero", {31'd0, zero}, 32'd1);
      cyc(4);
      peek("t3_r0", 0, 16'd0);
      check("t3_out_r0", {16'd0, out}, 32'd9);

      // Branches: not-taken, taken, PC wrap at 62.
      begin_test();
      mem[0]  = ins(5, 1, 0, 0, 16'd3);
      mem[4]  = ins(6, 0, 1, 0, 16'h0020);
      mem[6]  = ins(6, 0, 0, 0, 16'h003E);
      cyc(1);
      reset = 1'b0;
      cyc(12);
      check("t4_not_taken", {26'd0, imem_addr}, 32'd6);
      cyc(4);
      check("t4_taken_62", {26'd0, imem_addr}, 32'd62);
      cyc(4);
      check("t4_wrap", {26'd0, imem_addr}, 32'd0);

      // BEQZ r0 at pc 4 to 16, then a self-loop at 16.
      begin_test();
      mem[4]  = ins(6, 0, 0, 0, 16'h0010);
      mem[16] = ins(6, 0, 0, 0, 16'h0010);
      cyc(1);
      reset = 1'b0;
      cyc(12);
      check("t5_taken_16", {26'd0, imem_addr}, 32'd16);
      cyc(16);
      check("t5_self_loop", {26'd0, imem_addr}, 32'd16);

      // Delayed ack, then reset in the middle of a fetch wait.
      begin_test();
      mem[0] = ins(5, 2, 0, 0, 16'h1234);
      imem_ack = 1'b0;
      cyc(1);
      reset = 1'b0;
      cyc(5);
      check("t6_req_wait", {31'd0, imem_req}, 32'd1);
      check("t6_pc_wait", {26'd0, pc_out}, 32'd0);
      imem_ack = 1'b1;
      cyc(1);
      imem_ack = 1'b0;
      cyc(3);
      peek("t6_r2", 2, 16'h1234);
      check("t6_pc", {26'd0, pc_out}, 32'd2);
      cyc(2);
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      #1;
      check("t6_pc_reset", {26'd0, pc_out}, 32'd0);
      peek("t6_r2_reset", 2, 16'd0);

      // HALT freezes the core until reset.
      begin_test();
      mem[0] = ins(5, 5, 0, 0, 16'h002A);
      mem[2] = ins(7, 0, 0, 0, 16'd0);
      imem_ack = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(5);
      check("t7_not_yet_halted", {31'd0, halted}, 32'd0);
      cyc(1);
      check("t7_halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         check("t7_req_low", {31'd0, imem_req}, 32'd0);
         check("t7_out_frozen", {16'd0, out}, 32'h2A);
         check("t7_pc_frozen", {26'd0, pc_out}, 32'd2);
      end
      reset = 1'b1;
      cyc(1);
      check("t7_halt_cleared", {31'd0, halted}, 32'd0);
      reset = 1'b0;
      #1;
      check("t7_refetch_req", {31'd0, imem_req}, 32'd1);
      check("t7_refetch_addr", {26'd0, imem_addr}, 32'd0);
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
